// File: rtl/zube_bus_master.sv
// Zube external-bus master: IDLE/SETUP/STROBE/HOLD sequencer with registered bus pins.
// Optional wait-state input is enabled by defining ZUBE_MASTER_WAIT_EN.
module zube_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_address,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] address_bus,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_oe,
  input  logic [7:0]  data_bus_in,
`ifdef ZUBE_MASTER_WAIT_EN
  input  logic        wait_b,
`endif
  output logic        write_strobe_b,
  output logic        read_strobe_b,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       is_write;
  logic       wait_ok;

`ifdef ZUBE_MASTER_WAIT_EN
  logic wait_q;

  always_ff @(posedge clk) begin
    if (reset) wait_q <= 1'b1;
    else       wait_q <= wait_b;
  end

  assign wait_ok = wait_q;
`else
  assign wait_ok = 1'b1;
`endif

  assign cmd_ready = (state == IDLE) && !reset;

  // cnt loads N-1 on phase entry and the phase ends on the edge where it reads 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      is_write       <= 1'b0;
      address_bus    <= 16'd0;
      data_bus_out   <= 8'd0;
      data_bus_oe    <= 1'b0;
      write_strobe_b <= 1'b1;
      read_strobe_b  <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 8'd0;
      busy           <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state        <= SETUP;
            cnt          <= SETUP_LD;
            is_write     <= cmd_write;
            address_bus  <= cmd_address;
            data_bus_out <= cmd_wdata;
            data_bus_oe  <= cmd_write;
            busy         <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state          <= STROBE;
            cnt            <= STROBE_LD;
            write_strobe_b <= !is_write;
            read_strobe_b  <= is_write;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (wait_ok) begin
            state          <= HOLD;
            cnt            <= HOLD_LD;
            write_strobe_b <= 1'b1;
            read_strobe_b  <= 1'b1;
            if (!is_write) rsp_rdata <= data_bus_in;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state       <= IDLE;
            data_bus_oe <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zube_bus_master.sv
// Self-checking bench for zube_bus_master (default build, no wait input).
// Expected pin values come from a cycle-index timing model of each transaction.
module tb_zube_bus_master;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 1;
  localparam int LAT = S + T + H;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_address;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] address_bus;
  logic [7:0]  data_bus_out;
  logic        data_bus_oe;
  logic [7:0]  data_bus_in;
  logic        write_strobe_b;
  logic        read_strobe_b;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [7:0]  last_rd = 8'd0;
  logic [15:0] last_addr = 16'd0;

  always #5 clk = ~clk;

  zube_bus_master #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(T),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_address   (cmd_address),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .address_bus   (address_bus),
    .data_bus_out  (data_bus_out),
    .data_bus_oe   (data_bus_oe),
    .data_bus_in   (data_bus_in),
    .write_strobe_b(write_strobe_b),
    .read_strobe_b (read_strobe_b),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ws"}, write_strobe_b, 1);
    chk({tag, "_rs"}, read_strobe_b, 1);
    chk({tag, "_oe"}, data_bus_oe, 0);
    chk({tag, "_addr"}, address_bus, 0);
    chk({tag, "_dout"}, data_bus_out, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, cmd_ready, 0);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      data_bus_in = 8'($urandom);
      chk("idle_rsp", rsp_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rdy", cmd_ready, 1);
      chk("idle_ws", write_strobe_b, 1);
      chk("idle_rs", read_strobe_b, 1);
      chk("idle_oe", data_bus_oe, 0);
      chk("idle_addr", address_bus, last_addr);
      chk("idle_rdata", rsp_rdata, last_rd);
    end
  endtask

  // mode: 0 drop cmd_valid, 1 random noise on command inputs, 2 hold cmd_valid
  task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                     input int din, input int mode, input int abort_k);
    logic [7:0] cap;
    logic       strobe;
    cap = 8'd0;
    chk("accept_rdy", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_address = a;
    cmd_wdata   = d;
    last_addr   = a;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      strobe = (k > S) && (k <= S + T);
      chk("addr", address_bus, a);
      chk("busy", busy, k <= LAT);
      chk("ws", write_strobe_b, !(w && strobe));
      chk("rs", read_strobe_b, !(!w && strobe));
      chk("oe", data_bus_oe, w && (k <= LAT));
      chk("rsp_valid", rsp_valid, k == LAT + 1);
      chk("cmd_ready", cmd_ready, k == LAT + 1);
      if (w) chk("dout", data_bus_out, d);
      if (k == LAT + 1) begin
        if (!w) last_rd = cap;
        chk("rdata", rsp_rdata, last_rd);
      end
      if (k == abort_k) begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk_reset_state("abort");
        reset     = 1'b0;
        last_rd   = 8'd0;
        last_addr = 16'd0;
        for (int j = 0; j < LAT + 3; j++) begin
          @(negedge clk);
          chk("post_abort_rsp", rsp_valid, 0);
          chk("post_abort_rdy", cmd_ready, 1);
          chk("post_abort_busy", busy, 0);
        end
        return;
      end
      if (din >= 0 && strobe) data_bus_in = 8'(din);
      else                    data_bus_in = 8'($urandom);
      if (k == S + T) cap = data_bus_in;
      if (k <= LAT && mode == 1) begin
        cmd_valid   = 1'($urandom);
        cmd_write   = 1'($urandom);
        cmd_address = 16'($urandom);
        cmd_wdata   = 8'($urandom);
      end else if (k <= LAT && mode == 2) begin
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_address = 16'd0;
    cmd_wdata   = 8'd0;
    data_bus_in = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", cmd_ready, 1);

    txn(1'b1, 16'hA000, 8'h5A, -1, 0, 0);
    idle(2);
    txn(1'b0, 16'hA001, 8'h00, 8'h3C, 0, 0);
    chk("read_3c", rsp_rdata, 8'h3C);
    idle(2);
    txn(1'b1, 16'hA000, 8'h11, -1, 2, 0);
    txn(1'b0, 16'hA001, 8'h00, -1, 0, 0);
    idle(1);
    txn(1'b1, 16'h1234, 8'h77, -1, 1, 0);
    idle(1);
    txn(1'b1, 16'hBEEF, 8'h99, -1, 0, 4);

    for (int i = 0; i < 24; i++) begin
      txn(1'($urandom), 16'($urandom), 8'($urandom), -1,
          int'($urandom_range(0, 2)), 0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zube_bus_master.md
ZUBE_BUS_MASTER -- requirements
Module: zube_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles address/data are stable before the strobe falls; legal range 1-255.
REQ-002 SHALL have parameter STROBE_CYCLES, default 4: minimum cycles the strobe is held low; legal range 1-255.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1: cycles address/data are held after the strobe rises; legal range 1-255.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have the command port: cmd_valid in 1 request; cmd_ready out 1 accept; cmd_write in 1 (1=write, 0=read); cmd_address in 16; cmd_wdata in 8.
REQ-006 SHALL have the response port: rsp_valid out 1 completion pulse; rsp_rdata out 8 read data.
REQ-007 SHALL have the external bus: address_bus out 16; data_bus_out out 8; data_bus_oe out 1 (1 = master drives data); data_bus_in in 8; write_strobe_b out 1 active-low; read_strobe_b out 1 active-low; busy out 1.

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD; all bus outputs registered.
REQ-009 SHALL drive cmd_ready = 1 only in IDLE with reset low; a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-010 SHALL on acceptance latch cmd_address, cmd_wdata, cmd_write, and enter SETUP; address_bus takes cmd_address in the first SETUP cycle.
REQ-011 SHALL in SETUP keep both strobes high, drive data_bus_out = cmd_wdata with data_bus_oe = 1 for writes, data_bus_oe = 0 for reads; remain SETUP_CYCLES cycles.
REQ-012 SHALL in STROBE drive write_strobe_b = 0 (write) or read_strobe_b = 0 (read), never both; remain STROBE_CYCLES cycles (subject to REQ-021).
REQ-013 SHALL for reads capture data_bus_in into rsp_rdata on the rising edge that ends the final STROBE cycle, while read_strobe_b is still low.
REQ-014 SHALL in HOLD keep both strobes high with address_bus, data_bus_out, data_bus_oe unchanged; remain HOLD_CYCLES cycles, then return to IDLE.
REQ-015 SHALL assert rsp_valid for exactly one cycle, the first IDLE cycle after HOLD; acceptance-edge to rsp_valid latency = SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles (7 at defaults).
REQ-016 SHALL permit a new command to be accepted in the rsp_valid cycle (back-to-back period = total+1 cycles, 8 at defaults).
REQ-017 SHALL in IDLE deassert data_bus_oe and both strobes, and hold address_bus and data_bus_out at last values; rsp_rdata changes only on a read capture.
REQ-018 SHALL drive busy = 1 in SETUP, STROBE, HOLD; 0 otherwise.
REQ-019 SHALL ignore cmd_valid and command inputs while not in IDLE; phase counters SHALL be 8 bits and never wrap within a phase.

Reset
REQ-020 SHALL on any edge with reset high (including mid-transaction) enter IDLE with write_strobe_b=1, read_strobe_b=1, data_bus_oe=0, address_bus=0, data_bus_out=0, rsp_rdata=0, rsp_valid=0, busy=0, cmd_ready=0; an aborted transaction SHALL produce no rsp_valid.

Configuration
REQ-021 SHALL, when macro ZUBE_MASTER_WAIT_EN is defined, add input wait_b (1, active-low) registered through one flop; STROBE SHALL end only on the edge where the counter has expired and the registered wait_b is 1; read capture per REQ-013 at that edge.
REQ-022 SHALL, when ZUBE_MASTER_WAIT_EN is undefined, have no wait_b port and a fixed STROBE length of STROBE_CYCLES.

Verification
REQ-023 Write 0x5A to 0xA000 at defaults -> address_bus=0xA000 from cycle 1, write_strobe_b low cycles 3-6, data_bus_oe high cycles 1-7, rsp_valid pulse cycle 8, read_strobe_b never low.
REQ-024 Read 0xA001 with data_bus_in=0x3C during strobe -> read_strobe_b low cycles 3-6, data_bus_oe stays 0, rsp_rdata=0x3C when rsp_valid pulses at cycle 8.
REQ-025 cmd_valid held high for write 0xA000/0x11 then read 0xA001 -> second accept in first command's rsp_valid cycle, second rsp_valid 8 cycles later.
REQ-026 reset pulsed during cycle 4 of a write -> write_strobe_b=1, data_bus_oe=0, address_bus=0 next cycle; no rsp_valid; cmd_ready=1 after reset drops.
REQ-027 cmd_valid toggled while busy=1 -> cmd_ready=0, no new transaction, latched address/data unchanged.
REQ-028 With ZUBE_MASTER_WAIT_EN, read with wait_b low for 6 cycles from strobe start -> strobe extended past 4 cycles, released one cycle after registered wait_b high, rsp_rdata sampled at that edge.
